vga_sync: RTL and testbench

Raster timing generator for the 640x480@60 Hz VGA path. Divides the 100 MHz board clock down to a pixel-rate enable and produces the pixel coordinates, active-video flag and sync pulses that the display renderers consume. Every shape renderer and the colour mux downstream are driven from its x, y and video_active outputs. Its hsync and vsync go straight to the VGA connector.

---
 rtl/vga_sync.sv | 87 ++++++++
 tb/tb_vga_sync.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/vga_sync.sv
// Raster timing generator: pixel-rate enable, h/v counters, active-video flag
// and sync pulses for a VGA raster, all decoded from the counter registers.
module vga_sync #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_active,
  output logic       hsync,
  output logic       vsync,
  output logic       pix_tick,
  output logic       frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

  // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly
  localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h;
  logic [9:0]       v;
  logic             h_wrap;
  logic             v_wrap;
  logic             hs_on;
  logic             vs_on;

  assign pix_tick = (div_cnt == DIV_LAST) && !reset;
  assign h_wrap   = (h == H_LAST);
  assign v_wrap   = (v == V_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      h       <= '0;
      v       <= '0;
    end else begin
      if (div_cnt == DIV_LAST)
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + 1'b1;

      if (pix_tick) begin
        if (h_wrap) begin
          h <= '0;
          v <= v_wrap ? 10'd0 : v + 10'd1;
        end else begin
          h <= h + 10'd1;
        end
      end
    end
  end

  // Outputs are pure decodes of h/v so they always line up with x/y
  assign hs_on = ({1'b0, h} >= HS_START) && ({1'b0, h} < HS_END);
  assign vs_on = ({1'b0, v} >= VS_START) && ({1'b0, v} < VS_END);

  assign x            = h;
  assign y            = v;
  assign video_active = ({1'b0, h} < H_ACT_END) && ({1'b0, v} < V_ACT_END);
  assign hsync        = hs_on ? SYNC_POL : ~SYNC_POL;
  assign vsync        = vs_on ? SYNC_POL : ~SYNC_POL;
  assign frame_end    = pix_tick && h_wrap && v_wrap;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: default, CLK_DIV=1/active-high-sync and a tiny raster,
// checked every cycle against an arithmetic model plus directed vectors.
module tb_vga_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d = 1'b1, rst_f = 1'b1, rst_s = 1'b1;

  logic [9:0] x_d, y_d, x_f, y_f, x_s, y_s;
  logic va_d, hs_d, vs_d, pt_d, fe_d;
  logic va_f, hs_f, vs_f, pt_f, fe_f;
  logic va_s, hs_s, vs_s, pt_s, fe_s;

  vga_sync u_def (
    .clk(clk), .reset(rst_d), .x(x_d), .y(y_d), .video_active(va_d),
    .hsync(hs_d), .vsync(vs_d), .pix_tick(pt_d), .frame_end(fe_d)
  );

  vga_sync #(.CLK_DIV(1), .SYNC_POL(1'b1)) u_fast (
    .clk(clk), .reset(rst_f), .x(x_f), .y(y_f), .video_active(va_f),
    .hsync(hs_f), .vsync(vs_f), .pix_tick(pt_f), .frame_end(fe_f)
  );

  vga_sync #(.CLK_DIV(2), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
             .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)) u_small (
    .clk(clk), .reset(rst_s), .x(x_s), .y(y_s), .video_active(va_s),
    .hsync(hs_s), .vsync(vs_s), .pix_tick(pt_s), .frame_end(fe_s)
  );

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  // clk edges since each instance left reset
  longint n_d = 0, n_f = 0, n_s = 0;
  always @(posedge clk or posedge rst_d) if (rst_d) n_d <= 0; else n_d <= n_d + 1;
  always @(posedge clk or posedge rst_f) if (rst_f) n_f <= 0; else n_f <= n_f + 1;
  always @(posedge clk or posedge rst_s) if (rst_s) n_s <= 0; else n_s <= n_s + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Packed as {x, y, video_active, hsync, vsync, pix_tick, frame_end}
  function automatic logic [24:0] model(input longint n, input bit r, input int div,
      input int ha, input int hfp, input int hsw, input int hbp,
      input int va, input int vfp, input int vsw, input int vbp, input bit pol);
    longint ht, vt, p, h, v;
    bit pt, fe, act, hs, vs;
    ht  = ha + hfp + hsw + hbp;
    vt  = va + vfp + vsw + vbp;
    p   = n / div;
    h   = p % ht;
    v   = (p / ht) % vt;
    pt  = !r && ((n % div) == div - 1);
    fe  = pt && (h == ht - 1) && (v == vt - 1);
    act = (h < ha) && (v < va);
    hs  = (h >= ha + hfp && h < ha + hfp + hsw) ? pol : !pol;
    vs  = (v >= va + vfp && v < va + vfp + vsw) ? pol : !pol;
    return {10'(h), 10'(v), act, hs, vs, pt, fe};
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("cyc_def", {7'd0, x_d, y_d, va_d, hs_d, vs_d, pt_d, fe_d},
          {7'd0, model(n_d, rst_d, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0)});
      chk("cyc_fast", {7'd0, x_f, y_f, va_f, hs_f, vs_f, pt_f, fe_f},
          {7'd0, model(n_f, rst_f, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1)});
      chk("cyc_small", {7'd0, x_s, y_s, va_s, hs_s, vs_s, pt_s, fe_s},
          {7'd0, model(n_s, rst_s, 2, 8, 1, 2, 1, 4, 1, 1, 1, 1'b0)});
    end
  end

  typedef struct {
    int n;
    int x;
    int y;
    bit pt;
    bit va;
    bit hs;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int g;
    int cnt;
    bit found;

    tbl[0]  = '{0,    0,   0, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{3,    0,   0, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{4,    1,   0, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{7,    1,   0, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{8,    2,   0, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{2559, 639, 0, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{2560, 640, 0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{2623, 655, 0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{2624, 656, 0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{3007, 751, 0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{3008, 752, 0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{3199, 799, 0, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{3200, 0,   1, 1'b0, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_def", {7'd0, x_d, y_d, va_d, hs_d, vs_d, pt_d, fe_d},
        {7'd0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    chk("rst_fast", {7'd0, x_f, y_f, va_f, hs_f, vs_f, pt_f, fe_f},
        {7'd0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

    @(posedge clk);
    #1;
    rst_d = 1'b0;
    rst_f = 1'b0;
    rst_s = 1'b0;

    foreach (tbl[i]) begin
      g = 0;
      do begin
        @(negedge clk);
        g++;
      end while (n_d < longint'(tbl[i].n) && g < 20000);
      chk($sformatf("tbl%0d_n", i), 32'(n_d), 32'(tbl[i].n));
      chk($sformatf("tbl%0d_x", i), {22'd0, x_d}, 32'(tbl[i].x));
      chk($sformatf("tbl%0d_y", i), {22'd0, y_d}, 32'(tbl[i].y));
      chk($sformatf("tbl%0d_pt", i), {31'd0, pt_d}, {31'd0, tbl[i].pt});
      chk($sformatf("tbl%0d_va", i), {31'd0, va_d}, {31'd0, tbl[i].va});
      chk($sformatf("tbl%0d_hs", i), {31'd0, hs_d}, {31'd0, tbl[i].hs});
    end

    // Tiny raster: wrap (11,6) -> (0,0) and frame_end cadence
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      if (fe_s) found = 1'b1;
    end
    chk("small_fe_seen", {31'd0, found}, 32'd1);
    chk("small_wrap_x", {22'd0, x_s}, 32'd11);
    chk("small_wrap_y", {22'd0, y_s}, 32'd6);
    @(negedge clk);
    chk("small_after_wrap", {10'd0, x_s, y_s, fe_s, pt_s}, 32'd0);
    cnt = 0;
    for (int k = 0; k < 504; k++) begin
      @(negedge clk);
      if (fe_s) cnt++;
    end
    chk("small_fe_count", 32'(cnt), 32'd3);

    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (pt_f) cnt++;
    end
    chk("fast_tick_count", 32'(cnt), 32'd100);

    // Mid-frame reset at (300,1) on the default instance
    g = 0;
    while (n_d != 4400 && g < 10000) begin
      @(negedge clk);
      g++;
    end
    chk("mid_pre_x", {22'd0, x_d}, 32'd300);
    chk("mid_pre_y", {22'd0, y_d}, 32'd1);
    @(posedge clk);
    #2;
    rst_d = 1'b1;
    #1;
    chk("mid_rst", {7'd0, x_d, y_d, va_d, hs_d, vs_d, pt_d, fe_d},
        {7'd0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    rst_d = 1'b0;
    @(negedge clk);
    chk("mid_c0_pt", {31'd0, pt_d}, 32'd0);
    repeat (3) @(negedge clk);
    chk("mid_c3_pt", {31'd0, pt_d}, 32'd1);
    chk("mid_c3_x", {22'd0, x_d}, 32'd0);
    @(negedge clk);
    chk("mid_c4_x", {22'd0, x_d}, 32'd1);

    repeat (200) @(negedge clk);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
